// File: rtl/exec_trace_buffer.sv
// Debug trace FIFO of {PC, ALU} pairs captured on each processor step, with a
// PC-match trigger that stops capture a fixed number of steps after the match.
module exec_trace_buffer #(
  parameter int DEPTH_LOG2   = 4,
  parameter int WRAP         = 1,
  parameter int POST_SAMPLES = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cpu_tick,
  input  logic [31:0]           i_pc_in,
  input  logic [31:0]           i_alu_in,
  input  logic                  i_freeze,
  input  logic                  i_clr_trace,
  input  logic                  i_trig_en,
  input  logic [31:0]           i_trig_pc,
  input  logic                  i_rd_ready,
  output logic                  o_rd_valid,
  output logic [31:0]           o_rd_pc,
  output logic [31:0]           o_rd_alu,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         L_DEPTH   = CW'(DEPTH);
  localparam logic [CW-1:0]         L_POST    = CW'(POST_SAMPLES);
  localparam logic [CW-1:0]         L_CNT_ONE = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] L_PTR_ONE = DEPTH_LOG2'(1);
  localparam logic                  L_WRAP_EN = (WRAP != 0);

  localparam logic [1:0] S_ARMED = 2'd0;
  localparam logic [1:0] S_POST  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [63:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic [1:0]            r_state;
  logic [CW-1:0]         r_post_cnt;

  logic                  w_full;
  logic                  w_valid;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_match;
  logic                  w_write;
  logic [DEPTH_LOG2-1:0] w_wr_ptr_nxt;
  logic [DEPTH_LOG2-1:0] w_rd_ptr_nxt;
  logic [CW-1:0]         w_count_nxt;
  logic                  w_ovf_set;
  logic [1:0]            w_state_nxt;
  logic [CW-1:0]         w_post_nxt;

  assign w_full  = (r_count == L_DEPTH);
  assign w_valid = (r_count != {CW{1'b0}});
  assign w_push  = i_cpu_tick & ~i_freeze & (r_state != S_DONE);
  assign w_pop   = w_valid & i_rd_ready;
  assign w_match = i_trig_en & (i_pc_in == i_trig_pc);
  // A push into a full buffer is only stored if a pop frees a slot or wrap mode overwrites the oldest.
  assign w_write = w_push & (w_pop | ~w_full | L_WRAP_EN);

  // Pointer, occupancy and overflow next-state
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    w_ovf_set    = 1'b0;
    if (w_push && w_pop) begin
      w_wr_ptr_nxt = r_wr_ptr + L_PTR_ONE;
      w_rd_ptr_nxt = r_rd_ptr + L_PTR_ONE;
    end else if (w_push && !w_full) begin
      w_wr_ptr_nxt = r_wr_ptr + L_PTR_ONE;
      w_count_nxt  = r_count + L_CNT_ONE;
    end else if (w_push) begin
      w_ovf_set = 1'b1;
      if (L_WRAP_EN) begin
        w_wr_ptr_nxt = r_wr_ptr + L_PTR_ONE;
        w_rd_ptr_nxt = r_rd_ptr + L_PTR_ONE;
      end else begin
        w_wr_ptr_nxt = r_wr_ptr;
      end
    end else if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + L_PTR_ONE;
      w_count_nxt  = r_count - L_CNT_ONE;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Trigger FSM next-state
  always_comb begin
    w_state_nxt = r_state;
    w_post_nxt  = r_post_cnt;
    case (r_state)
      S_ARMED: begin
        if (w_push && w_match) begin
          if (L_POST == {CW{1'b0}}) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_POST;
            w_post_nxt  = L_POST;
          end
        end else begin
          w_state_nxt = S_ARMED;
        end
      end
      S_POST: begin
        if (w_push) begin
          w_post_nxt = r_post_cnt - L_CNT_ONE;
          if (r_post_cnt == L_CNT_ONE) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_POST;
          end
        end else begin
          w_state_nxt = S_POST;
        end
      end
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_ARMED;
    endcase
  end

  // Control state registers; clear overrides any same-cycle push or pop
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_trace) begin
      r_wr_ptr   <= {DEPTH_LOG2{1'b0}};
      r_rd_ptr   <= {DEPTH_LOG2{1'b0}};
      r_count    <= {CW{1'b0}};
      r_overflow <= 1'b0;
      r_state    <= S_ARMED;
      r_post_cnt <= {CW{1'b0}};
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_overflow <= r_overflow | w_ovf_set;
      r_state    <= w_state_nxt;
      r_post_cnt <= w_post_nxt;
    end
  end

  // Trace storage, not reset
  always_ff @(posedge i_clk) begin
    if (w_write && !i_rst && !i_clr_trace) begin
      r_mem[r_wr_ptr] <= {i_pc_in, i_alu_in};
    end
  end

  assign o_rd_valid = w_valid;
  assign o_rd_pc    = w_valid ? r_mem[r_rd_ptr][63:32] : 32'd0;
  assign o_rd_alu   = w_valid ? r_mem[r_rd_ptr][31:0]  : 32'd0;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_done     = (r_state == S_DONE);

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Directed bench for exec_trace_buffer: a wrap-mode instance and a drop-mode
// instance share stimulus; drop-mode results are checked where they differ.
module tb_exec_trace_buffer;

  logic        clk, rst, tick, freeze, clr, trig_en, ready;
  logic [31:0] pc, alu, trig_pc;
  logic        v0, v1, ovf0, ovf1, done0, done1;
  logic [31:0] pc0, pc1, alu0, alu1;
  logic [4:0]  cnt0, cnt1;
  int          total, bad;

  exec_trace_buffer #(.DEPTH_LOG2(4), .WRAP(1), .POST_SAMPLES(8)) dut_wrap (
    .i_clk(clk), .i_rst(rst), .i_cpu_tick(tick), .i_pc_in(pc), .i_alu_in(alu),
    .i_freeze(freeze), .i_clr_trace(clr), .i_trig_en(trig_en), .i_trig_pc(trig_pc),
    .i_rd_ready(ready), .o_rd_valid(v0), .o_rd_pc(pc0), .o_rd_alu(alu0),
    .o_count(cnt0), .o_overflow(ovf0), .o_done(done0));

  exec_trace_buffer #(.DEPTH_LOG2(4), .WRAP(0), .POST_SAMPLES(8)) dut_drop (
    .i_clk(clk), .i_rst(rst), .i_cpu_tick(tick), .i_pc_in(pc), .i_alu_in(alu),
    .i_freeze(freeze), .i_clr_trace(clr), .i_trig_en(trig_en), .i_trig_pc(trig_pc),
    .i_rd_ready(ready), .o_rd_valid(v1), .o_rd_pc(pc1), .o_rd_alu(alu1),
    .o_count(cnt1), .o_overflow(ovf1), .o_done(done1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tick;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        freeze;
    logic        clr;
    logic        ready;
    logic [4:0]  e_count;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_alu;
    logic        e_ovf;
    logic        e_done;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] a);
    tick = 1'b1; pc = p; alu = a;
    cyc();
    tick = 1'b0;
  endtask

  task automatic pop_n(input int n);
    ready = 1'b1;
    repeat (n) cyc();
    ready = 1'b0;
  endtask

  task automatic clear();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; tick = 1'b0; freeze = 1'b0; clr = 1'b0; trig_en = 1'b0; ready = 1'b0;
    pc = 32'd0; alu = 32'd0; trig_pc = 32'd0;

    //                tick  pc          alu        frz   clr   rdy   cnt  vld   hpc         halu       ovf   done
    vecs[0] = '{1'b1, 32'h0,     32'h1,  1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 32'h0,     32'h1,  1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h4,     32'h2,  1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 32'h0,     32'h1,  1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h8,     32'h3,  1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 32'h0,     32'h1,  1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h0,     32'h0,  1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 32'h4,     32'h2,  1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h0,     32'h0,  1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 32'h8,     32'h3,  1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h0,     32'h0,  1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0,     32'h0,  1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h100,   32'h55, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 32'h100,   32'h55, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 32'h200,   32'h77, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 32'h100,   32'h55, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 32'h300,   32'h66, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 32'h300,   32'h66, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 32'h400,   32'h88, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 32'h0,     32'h0,  1'b0, 1'b0};

    cyc(); cyc();
    rst = 1'b0;
    chk("rst.count", 32'(cnt0), 32'd0);
    chk("rst.valid", 32'(v0), 32'd0);
    chk("rst.pc", pc0, 32'd0);
    chk("rst.alu", alu0, 32'd0);
    chk("rst.ovf", 32'(ovf0), 32'd0);
    chk("rst.done", 32'(done0), 32'd0);

    // basic push/pop, empty push with ready, freeze, push+pop, clear
    for (int i = 0; i < NV; i++) begin
      tick = vecs[i].tick; pc = vecs[i].pc; alu = vecs[i].alu;
      freeze = vecs[i].freeze; clr = vecs[i].clr; ready = vecs[i].ready;
      cyc();
      chk($sformatf("vec%0d.count", i), 32'(cnt0), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d.valid", i), 32'(v0), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d.pc", i), pc0, vecs[i].e_pc);
      chk($sformatf("vec%0d.alu", i), alu0, vecs[i].e_alu);
      chk($sformatf("vec%0d.ovf", i), 32'(ovf0), 32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d.done", i), 32'(done0), 32'(vecs[i].e_done));
    end
    tick = 1'b0; freeze = 1'b0; clr = 1'b0; ready = 1'b0;

    // overflow: wrap overwrites oldest, drop discards newest
    clear();
    for (int i = 0; i < 18; i++) push(32'(4 * i), 32'(i));
    chk("wrap.count", 32'(cnt0), 32'd16);
    chk("wrap.ovf", 32'(ovf0), 32'd1);
    chk("wrap.head", pc0, 32'd8);
    chk("drop.count", 32'(cnt1), 32'd16);
    chk("drop.ovf", 32'(ovf1), 32'd1);
    chk("drop.head", pc1, 32'd0);
    pop_n(15);
    chk("wrap.tail", pc0, 32'd68);
    chk("drop.tail", pc1, 32'd60);
    chk("drop.tail_alu", alu1, 32'd15);
    chk("drop.tail_count", 32'(cnt1), 32'd1);

    // full buffer, push and pop in the same cycle
    clear();
    for (int i = 0; i < 16; i++) push(32'(4 * i), 32'(i));
    chk("full.ovf_before", 32'(ovf0), 32'd0);
    ready = 1'b1;
    push(32'h400, 32'h99);
    ready = 1'b0;
    chk("fullpp.count", 32'(cnt0), 32'd16);
    chk("fullpp.ovf", 32'(ovf0), 32'd0);
    chk("fullpp.head", pc0, 32'd4);
    chk("fullpp.drop_ovf", 32'(ovf1), 32'd0);
    chk("fullpp.drop_head", pc1, 32'd4);
    pop_n(15);
    chk("fullpp.tail", pc0, 32'h400);
    chk("fullpp.drop_tail", pc1, 32'h400);

    // trigger at 0x20, eight post samples
    clear();
    trig_en = 1'b1; trig_pc = 32'h20;
    for (int k = 0; k < 16; k++) push(32'(4 * k), 32'(k));
    chk("trig.done_early", 32'(done0), 32'd0);
    push(32'h40, 32'd16);
    chk("trig.done", 32'(done0), 32'd1);
    chk("trig.count", 32'(cnt0), 32'd16);
    for (int k = 17; k < 20; k++) push(32'(4 * k), 32'(k));
    chk("trig.count_hold", 32'(cnt0), 32'd16);
    chk("trig.done_hold", 32'(done0), 32'd1);
    pop_n(15);
    chk("trig.tail", pc0, 32'h40);
    chk("trig.done_drain", 32'(done0), 32'd1);

    // freeze during post-trigger window
    clear();
    for (int k = 0; k < 12; k++) push(32'(4 * k), 32'(k));
    freeze = 1'b1;
    for (int j = 0; j < 5; j++) push(32'hBAD0 + 32'(j), 32'd0);
    freeze = 1'b0;
    chk("frz.count", 32'(cnt0), 32'd12);
    chk("frz.done", 32'(done0), 32'd0);
    for (int k = 12; k < 16; k++) push(32'(4 * k), 32'(k));
    chk("frz.done_early", 32'(done0), 32'd0);
    push(32'h40, 32'd16);
    chk("frz.done", 32'(done0), 32'd1);
    chk("frz.drop_done", 32'(done1), 32'd1);
    chk("frz.count16", 32'(cnt0), 32'd16);
    chk("frz.head", pc0, 32'd4);

    // clear in DONE with simultaneous push and pop
    trig_en = 1'b0;
    clr = 1'b1; ready = 1'b1;
    push(32'h500, 32'h5);
    clr = 1'b0; ready = 1'b0;
    chk("clr.count", 32'(cnt0), 32'd0);
    chk("clr.ovf", 32'(ovf0), 32'd0);
    chk("clr.done", 32'(done0), 32'd0);
    chk("clr.valid", 32'(v0), 32'd0);
    chk("clr.pc", pc0, 32'd0);
    push(32'h600, 32'h7);
    chk("clr.count1", 32'(cnt0), 32'd1);
    chk("clr.head", pc0, 32'h600);
    chk("clr.head_alu", alu0, 32'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
